// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults and helpers for the multi-port register file
package rf_pkg;

  localparam int RF_XLEN     = 32;
  localparam int RF_NREGS    = 32;
  localparam int RF_ZERO_REG = 0;

  // Widest busy vector popcount() accepts; narrower vectors are zero-padded.
  localparam int RF_POP_MAX  = 256;

  function automatic int popcount(input logic [RF_POP_MAX-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < RF_POP_MAX; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-write busy vector with set/clear/flush priority
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = RF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_set_valid,
  input  logic [AW-1:0]    i_set_idx,
  input  logic             i_clr_valid,
  input  logic [AW-1:0]    i_clr_idx,
  input  logic             i_flush,
  output logic [NREGS-1:0] o_busy,
  output logic [AW:0]      o_pending_count
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(RF_ZERO_REG);

  logic [NREGS-1:0]      r_busy;
  logic [AW:0]           r_count;
  logic [NREGS-1:0]      w_busy_next;
  logic [RF_POP_MAX-1:0] w_pop_in;

  // Set is applied after clear so a newer producer on the same index wins.
  always_comb begin
    w_busy_next = r_busy;
    if (i_clr_valid && (i_clr_idx != ZERO_IDX)) begin
      w_busy_next[i_clr_idx] = 1'b0;
    end
    if (i_set_valid && (i_set_idx != ZERO_IDX)) begin
      w_busy_next[i_set_idx] = 1'b1;
    end
    if (i_flush) begin
      w_busy_next = '0;
    end
    w_busy_next[RF_ZERO_REG] = 1'b0;
  end

  always_comb begin
    w_pop_in = '0;
    w_pop_in[NREGS-1:0] = w_busy_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= w_busy_next;
      r_count <= (AW+1)'(popcount(w_pop_in));
    end
  end

  assign o_busy          = r_busy;
  assign o_pending_count = r_count;

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-read-port register file with write bypass and hazard scoreboard
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                RegWrite,
  input  logic [AW-1:0]       Rd,
  input  logic [XLEN-1:0]     Write_data,
  input  logic [NRD*AW-1:0]   Rs,
  output logic [NRD*XLEN-1:0] read_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  input  logic                flush,
  output logic [AW:0]         pending_count
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(RF_ZERO_REG);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] w_busy;
  logic             w_wr_en;

  assign w_wr_en = RegWrite && (Rd != ZERO_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[Rd] <= Write_data;
    end
  end

  // A same-cycle writeback both forwards its data and masks the stale busy bit.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   w_rs;
    logic [XLEN-1:0] w_rdata;
    logic            w_hit;

    assign w_rs  = Rs[p*AW +: AW];
    assign w_hit = RegWrite && (Rd == w_rs);

    always_comb begin
      if (w_rs == ZERO_IDX) begin
        w_rdata = '0;
      end else if (w_hit) begin
        w_rdata = Write_data;
      end else begin
        w_rdata = r_regs[w_rs];
      end
    end

    assign read_data[p*XLEN +: XLEN] = w_rdata;
    assign rs_busy[p] = w_busy[w_rs] && !w_hit;
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk             (clk),
    .reset           (reset),
    .i_set_valid     (issue_valid),
    .i_set_idx       (issue_rd),
    .i_clr_valid     (RegWrite),
    .i_clr_idx       (Rd),
    .i_flush         (flush),
    .o_busy          (w_busy),
    .o_pending_count (pending_count)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench for reg_file_mp against a behavioural model
module tb_reg_file_mp;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  Rd;
  logic [31:0] Write_data;
  logic [9:0]  Rs;
  logic [63:0] read_data;
  logic [1:0]  rs_busy;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [5:0]  pending_count;

  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .Rd            (Rd),
    .Write_data    (Write_data),
    .Rs            (Rs),
    .read_data     (read_data),
    .rs_busy       (rs_busy),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .flush         (flush),
    .pending_count (pending_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic [1:0]  busy;
    logic [5:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  int          vectors;
  int          miscompares;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] rs, input logic rw,
                                         input logic [4:0] rd, input logic [31:0] wd);
    if (rs == 0) return 32'h0;
    if (rw && rd == rs) return wd;
    return m_regs[rs];
  endfunction

  function automatic logic m_busy_of(input logic [4:0] rs, input logic rw, input logic [4:0] rd);
    if (rs == 0) return 1'b0;
    if (rw && rd == rs) return 1'b0;
    return m_busy[rs];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 0;
    end
  endtask

  // Called just after a rising edge; applies one cycle of stimulus.
  task automatic drive(input logic rw, input logic [4:0] rd, input logic [31:0] wd,
                       input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic iv, input logic [4:0] ird, input logic fl);
    exp_t e;
    int   c;
    RegWrite    = rw;
    Rd          = rd;
    Write_data  = wd;
    Rs          = {rs1, rs0};
    issue_valid = iv;
    issue_rd    = ird;
    flush       = fl;
    e.rdata = {m_read(rs1, rw, rd, wd), m_read(rs0, rw, rd, wd)};
    e.busy  = {m_busy_of(rs1, rw, rd), m_busy_of(rs0, rw, rd)};
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    e.cnt = c[5:0];
    exp_q.push_back(e);
    @(posedge clk);
    if (rw && rd != 0) m_regs[rd] = wd;
    if (fl) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else begin
      if (rw && rd != 0) m_busy[rd] = 0;
      if (iv && ird != 0) m_busy[ird] = 1;
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      check("read_data", read_data, e.rdata);
      check("rs_busy", {62'h0, rs_busy}, {62'h0, e.busy});
      check("pending_count", {58'h0, pending_count}, {58'h0, e.cnt});
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    reset       = 1'b1;
    RegWrite    = 1'b0;
    Rd          = '0;
    Write_data  = '0;
    Rs          = {5'd0, 5'd5};
    issue_valid = 1'b0;
    issue_rd    = '0;
    flush       = 1'b0;
    #1;
    vectors++;
    check("reset_read_data", read_data, 64'h0);
    check("reset_rs_busy", {62'h0, rs_busy}, 64'h0);
    check("reset_pending", {58'h0, pending_count}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    drive(0, 0, 32'h0,        5, 0, 0, 0, 0);
    drive(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0);
    drive(0, 0, 32'h0,        5, 0, 0, 0, 0);
    drive(1, 0, 32'h1234,     0, 5, 0, 0, 0);
    drive(0, 0, 32'h0,        7, 0, 1, 7, 0);
    drive(1, 7, 32'h55,       7, 0, 0, 0, 0);
    drive(0, 0, 32'h0,        7, 9, 0, 0, 0);
    drive(1, 9, 32'h99,       9, 0, 1, 9, 0);
    drive(1, 9, 32'h77,       9, 3, 1, 3, 0);
    drive(0, 0, 32'h0,        9, 3, 0, 0, 0);
    drive(0, 0, 32'h0,        0, 0, 1, 1, 0);
    drive(0, 0, 32'h0,        1, 0, 1, 2, 0);
    drive(0, 0, 32'h0,        2, 1, 1, 3, 0);
    drive(0, 0, 32'h0,        3, 2, 1, 4, 1);
    drive(0, 0, 32'h0,        5, 4, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
            ($urandom_range(0, 15) == 0));
    end

    drive(1, 10, 32'hA5A5A5A5, 0, 0, 1, 10, 0);
    drive(0, 0, 32'h0, 10, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    RegWrite    = 1'b0;
    issue_valid = 1'b0;
    flush       = 1'b0;
    Rs          = {5'd0, 5'd10};
    reset       = 1'b1;
    #1;
    vectors++;
    check("midreset_read_data", read_data, 64'h0);
    check("midreset_rs_busy", {62'h0, rs_busy}, 64'h0);
    check("midreset_pending", {58'h0, pending_count}, 64'h0);
    #1;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    drive(0, 0, 32'h0, 10, 5, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses never checked, required 0", exp_q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
